// File: rtl/dmem_responder.sv
// Variable-latency data-memory responder for the MEM-stage load/store interface.
// Optional macro DMEM_MISALIGN_CHECK_EN: misaligned half/word accesses fault instead of being forced to alignment.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t          state, state_next;
  logic [CW-1:0]   cnt, cnt_next;
  logic            req_ready_next, resp_valid_next, resp_err_next;
  logic [31:0]     resp_rdata_next;

  logic [AW+1:0]   addr_q;
  logic            we_q, uns_q;
  logic [1:0]      size_q;
  logic [31:0]     wdata_q;

  logic [31:0]     mem [DEPTH_WORDS];

  logic            accept, access, wr_en, err;
  logic [AW-1:0]   idx;
  logic [1:0]      lane;
  logic [3:0]      be;
  logic [4:0]      shamt;
  logic [31:0]     rd_word, rd_shift, wd_shift, mask, merged, load_data;
  logic            addr_hi_unused;

  assign accept         = req_valid && req_ready;
  assign access         = (state == BUSY) && (cnt == '0);
  assign idx            = addr_q[AW+1:2];
  assign addr_hi_unused = ^req_addr[31:AW+2];

  // Request fields are captured only at acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      wdata_q <= '0;
    end else if (accept) begin
      addr_q  <= req_addr[AW+1:0];
      we_q    <= req_we;
      size_q  <= req_size;
      uns_q   <= req_unsigned;
      wdata_q <= req_wdata;
    end
  end

  // Lane selection, fault detection and byte-lane merge for the latched request.
  always_comb begin
    err  = (size_q == 2'b11);
    lane = 2'b00;
    be   = 4'b0000;
`ifdef DMEM_MISALIGN_CHECK_EN
    if ((size_q == 2'b01) && addr_q[0])          err = 1'b1;
    if ((size_q == 2'b10) && (addr_q[1:0] != 2'b00)) err = 1'b1;
`endif
    case (size_q)
      2'b00: begin lane = addr_q[1:0];        be = 4'b0001 << lane; end
      2'b01: begin lane = {addr_q[1], 1'b0};  be = 4'b0011 << lane; end
      2'b10: begin lane = 2'b00;              be = 4'b1111;         end
      default: begin lane = 2'b00;            be = 4'b0000;         end
    endcase
    shamt    = {lane, 3'b000};
    rd_word  = mem[idx];
    rd_shift = rd_word >> shamt;
    wd_shift = wdata_q << shamt;
    for (int i = 0; i < 4; i++) mask[8*i +: 8] = {8{be[i]}};
    merged   = (rd_word & ~mask) | (wd_shift & mask);
    case (size_q)
      2'b00:   load_data = {(uns_q ? 24'h0 : {24{rd_shift[7]}}),  rd_shift[7:0]};
      2'b01:   load_data = {(uns_q ? 16'h0 : {16{rd_shift[15]}}), rd_shift[15:0]};
      2'b10:   load_data = rd_shift;
      default: load_data = 32'h0;
    endcase
  end

  assign wr_en = access && we_q && !err;

  // Array contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[idx] <= merged;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      req_ready  <= req_ready_next;
      resp_valid <= resp_valid_next;
      resp_rdata <= resp_rdata_next;
      resp_err   <= resp_err_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = BUSY;
          cnt_next   = CW'(LATENCY - 1);
        end
      end
      BUSY: begin
        if (cnt == '0) state_next = RESP;
        else           cnt_next   = cnt - CW'(1);
      end
      RESP: begin
        if (resp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Handshake flags follow the next state so they are registered alongside it.
  always_comb begin
    req_ready_next  = (state_next == IDLE);
    resp_valid_next = (state_next == RESP);
    resp_rdata_next = resp_rdata;
    resp_err_next   = resp_err;
    if (access) begin
      resp_rdata_next = (we_q || err) ? 32'h0 : load_data;
      resp_err_next   = err;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder (DEPTH_WORDS=1024, LATENCY=2).
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  // Drives one request, waits for accept and response, consumes it (resp_ready assumed 1).
  task automatic xact(input logic we, input logic [1:0] size, input logic uns,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      output logic [31:0] rdata, output logic err, output int lat);
    int k;
    @(negedge clk);
    req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1;
    k = 0;
    while (!req_ready && k < 20) begin @(negedge clk); k++; end
    if (!req_ready) begin
      req_valid = 1'b0; rdata = 32'hx; err = 1'bx; lat = 99;
    end else begin
      @(posedge clk); #1;
      req_valid = 1'b0;
      lat = 0;
      while (!resp_valid && lat < 40) begin @(posedge clk); #1; lat++; end
      rdata = resp_rdata; err = resp_err;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
    n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid); end
    n_checks++; if (resp_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", resp_rdata); end
    n_checks++; if (resp_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", resp_err); end
  endtask

  task automatic test_basic();
    logic [31:0] rd; logic er; int lt;
    xact(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, rd, er, lt);
    n_checks++; if (lt != 2) begin n_fail++; $display("FAIL basic_store_latency: got %0d want 2", lt); end
    n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL basic_store_rdata: got %h want 0", rd); end
    xact(1'b0, 2'b10, 1'b1, 32'h10, 32'h0, rd, er, lt);
    n_checks++; if (lt != 2) begin n_fail++; $display("FAIL basic_load_latency: got %0d want 2", lt); end
    n_checks++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL basic_load_rdata: got %h want deadbeef", rd); end
    n_checks++; if (er !== 1'b0) begin n_fail++; $display("FAIL basic_load_err: got %b want 0", er); end
  endtask

  task automatic test_byte_merge();
    logic [31:0] rd; logic er; int lt;
    xact(1'b1, 2'b10, 1'b0, 32'h10, 32'h11223344, rd, er, lt);
    xact(1'b1, 2'b00, 1'b0, 32'h13, 32'hFFFFFFAA, rd, er, lt);
    xact(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, er, lt);
    n_checks++; if (rd !== 32'hAA223344) begin n_fail++; $display("FAIL byte_merge_word: got %h want aa223344", rd); end
    xact(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, rd, er, lt);
    n_checks++; if (rd !== 32'hFFFFFFAA) begin n_fail++; $display("FAIL byte_load_signed: got %h want ffffffaa", rd); end
    xact(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, rd, er, lt);
    n_checks++; if (rd !== 32'h000000AA) begin n_fail++; $display("FAIL byte_load_unsigned: got %h want 000000aa", rd); end
    xact(1'b0, 2'b00, 1'b0, 32'h11, 32'h0, rd, er, lt);
    n_checks++; if (rd !== 32'h00000033) begin n_fail++; $display("FAIL byte_load_lane1: got %h want 00000033", rd); end
  endtask

  task automatic test_half();
    logic [31:0] rd; logic er; int lt;
    xact(1'b1, 2'b10, 1'b0, 32'h20, 32'h11223344, rd, er, lt);
    xact(1'b1, 2'b01, 1'b0, 32'h22, 32'h00008001, rd, er, lt);
    xact(1'b0, 2'b01, 1'b0, 32'h22, 32'h0, rd, er, lt);
    n_checks++; if (rd !== 32'hFFFF8001) begin n_fail++; $display("FAIL half_load_signed: got %h want ffff8001", rd); end
    xact(1'b0, 2'b01, 1'b1, 32'h22, 32'h0, rd, er, lt);
    n_checks++; if (rd !== 32'h00008001) begin n_fail++; $display("FAIL half_load_unsigned: got %h want 00008001", rd); end
    xact(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, rd, er, lt);
    n_checks++; if (rd !== 32'h80013344) begin n_fail++; $display("FAIL half_merge_word: got %h want 80013344", rd); end
  endtask

  task automatic test_back_to_back();
    int k; int lt;
    resp_ready = 1'b0;
    @(negedge clk);
    req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b1; req_addr = 32'h10; req_wdata = 32'h0;
    req_valid = 1'b1;
    k = 0;
    while (!req_ready && k < 20) begin @(negedge clk); k++; end
    @(posedge clk); #1;
    lt = 0;
    while (!resp_valid && lt < 40) begin @(posedge clk); #1; lt++; end
    n_checks++; if (lt != 2) begin n_fail++; $display("FAIL bp_latency: got %0d want 2", lt); end
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      n_checks++; if (resp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid_held: cycle %0d got %b want 1", c, resp_valid); end
      n_checks++; if (resp_rdata !== 32'hAA223344) begin n_fail++; $display("FAIL bp_rdata_held: cycle %0d got %h want aa223344", c, resp_rdata); end
      n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL bp_req_ready_low: cycle %0d got %b want 0", c, req_ready); end
    end
    @(negedge clk); resp_ready = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL bp_valid_drop: got %b want 0", resp_valid); end
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_after_hs: got %b want 1", req_ready); end
    @(posedge clk); #1;
    n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL bp_next_accept: got req_ready %b want 0", req_ready); end
    req_valid = 1'b0;
    lt = 0;
    while (!resp_valid && lt < 40) begin @(posedge clk); #1; lt++; end
    n_checks++; if (lt != 2) begin n_fail++; $display("FAIL bp_second_latency: got %0d want 2", lt); end
    n_checks++; if (resp_rdata !== 32'hAA223344) begin n_fail++; $display("FAIL bp_second_rdata: got %h want aa223344", resp_rdata); end
    @(posedge clk); #1;
  endtask

  task automatic test_wrap_illegal();
    logic [31:0] rd; logic er; int lt;
    xact(1'b1, 2'b10, 1'b0, 32'h1000, 32'h00000055, rd, er, lt);
    xact(1'b0, 2'b10, 1'b0, 32'h0, 32'h0, rd, er, lt);
    n_checks++; if (rd !== 32'h00000055) begin n_fail++; $display("FAIL wrap_load: got %h want 00000055", rd); end
    xact(1'b1, 2'b11, 1'b0, 32'h0, 32'hFFFFFFFF, rd, er, lt);
    n_checks++; if (er !== 1'b1) begin n_fail++; $display("FAIL illegal_store_err: got %b want 1", er); end
    n_checks++; if (lt != 2) begin n_fail++; $display("FAIL illegal_store_latency: got %0d want 2", lt); end
    xact(1'b0, 2'b11, 1'b0, 32'h0, 32'h0, rd, er, lt);
    n_checks++; if (er !== 1'b1 || rd !== 32'h0) begin n_fail++; $display("FAIL illegal_load: got err %b rdata %h want 1 00000000", er, rd); end
    xact(1'b0, 2'b10, 1'b0, 32'h0, 32'h0, rd, er, lt);
    n_checks++; if (rd !== 32'h00000055 || er !== 1'b0) begin n_fail++; $display("FAIL illegal_no_write: got %h err %b want 00000055 0", rd, er); end
  endtask

  task automatic test_misalign();
    logic [31:0] rd; logic er; int lt;
    xact(1'b0, 2'b10, 1'b0, 32'h2, 32'h0, rd, er, lt);
    n_checks++; if (lt != 2) begin n_fail++; $display("FAIL misalign_latency: got %0d want 2", lt); end
`ifdef DMEM_MISALIGN_CHECK_EN
    n_checks++; if (er !== 1'b1 || rd !== 32'h0) begin n_fail++; $display("FAIL misalign_word: got err %b rdata %h want 1 00000000", er, rd); end
`else
    n_checks++; if (er !== 1'b0 || rd !== 32'h00000055) begin n_fail++; $display("FAIL misalign_word: got err %b rdata %h want 0 00000055", er, rd); end
`endif
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic er; int lt; int k; logic seen;
    xact(1'b1, 2'b10, 1'b0, 32'h30, 32'h0BADC0DE, rd, er, lt);
    @(negedge clk);
    req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 32'h30; req_wdata = 32'hCAFEF00D;
    req_valid = 1'b1;
    k = 0;
    while (!req_ready && k < 20) begin @(negedge clk); k++; end
    @(posedge clk); #1;
    req_valid = 1'b0;
    n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy: got req_ready %b want 0", req_ready); end
    @(negedge clk); rst_n = 1'b0; #1;
    n_checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_outputs: got ready %b valid %b want 1 0", req_ready, resp_valid); end
    @(negedge clk); rst_n = 1'b1;
    seen = 1'b0;
    repeat (5) begin @(posedge clk); #1; if (resp_valid) seen = 1'b1; end
    n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL rst_mid_no_resp: got resp_valid seen %b want 0", seen); end
    xact(1'b0, 2'b10, 1'b0, 32'h30, 32'h0, rd, er, lt);
    n_checks++; if (rd !== 32'h0BADC0DE) begin n_fail++; $display("FAIL rst_mid_no_write: got %h want 0badc0de", rd); end
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0; resp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk); rst_n = 1'b1;
    test_basic();
    test_byte_merge();
    test_half();
    test_back_to_back();
    test_wrap_illegal();
    test_misalign();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
